// File: rtl/karplus_voice_alloc.sv
// Voice allocator and pluck sequencer for a bank of karplus string voices.
// Timing is counted in audio ticks recovered from the asynchronous audiolrclk.
module karplus_voice_alloc #(
    parameter int NUM_VOICES    = 4,
    parameter int NOTE_W        = 9,
    parameter int RELEASE_TICKS = 4800,
    parameter int REARM_TICKS   = 2
) (
    input  logic                         clock50,
    input  logic                         reset,
    input  logic                         audiolrclk,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_on,
    input  logic [NOTE_W-1:0]            req_note,
    input  logic [17:0]                  sustain_gain,
    input  logic [17:0]                  damp_gain,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_pluck,
    output logic [NUM_VOICES*18-1:0]     voice_gain,
    output logic [NUM_VOICES-1:0]        voice_busy,
    output logic                         drop_pulse
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int REL_W = $clog2(RELEASE_TICKS + 1);
    localparam int RA_W  = $clog2(REARM_TICKS + 1);
    localparam int CNT_A = (REL_W > NOTE_W + 1) ? REL_W : NOTE_W + 1;
    localparam int CNT_W = (CNT_A > RA_W) ? CNT_A : RA_W;

    localparam logic [NOTE_W-1:0] NOTE_MIN = NOTE_W'(2);
    localparam logic [NOTE_W-1:0] NOTE_MAX = NOTE_W'((1 << NOTE_W) - 3);
    localparam logic [CNT_W-1:0]  REARM_LAST = CNT_W'(REARM_TICKS - 1);
    localparam logic [CNT_W-1:0]  REL_LAST   = CNT_W'(RELEASE_TICKS - 1);

    typedef enum logic [1:0] {
        C_ACCEPT,
        C_SEARCH,
        C_COMMIT
    } ctrl_t;

    typedef enum logic [2:0] {
        V_IDLE,
        V_REARM,
        V_PLUCK,
        V_SUSTAIN,
        V_RELEASE
    } vstate_t;

    // lr_sync[1:0] is the 2-flop synchronizer, lr_sync[2] the edge history
    logic [2:0] lr_sync;
    logic       tick;

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            lr_sync <= '0;
        end else begin
            lr_sync <= {lr_sync[1:0], audiolrclk};
        end
    end

    assign tick = lr_sync[1] & ~lr_sync[2];

    vstate_t           st_arr   [NUM_VOICES];
    logic [7:0]        age_arr  [NUM_VOICES];
    logic [NOTE_W-1:0] note_arr [NUM_VOICES];

    ctrl_t                 ctrl;
    logic                  cap_on;
    logic [NOTE_W-1:0]     cap_note;
    logic                  note_ok;
    logic [IDX_W-1:0]      tgt;
    logic [NUM_VOICES-1:0] off_vec;

    logic                  hit_any;
    logic                  idle_any;
    logic [IDX_W-1:0]      hit_idx;
    logic [IDX_W-1:0]      idle_idx;
    logic [IDX_W-1:0]      old_idx;
    logic [7:0]            old_age;
    logic [NUM_VOICES-1:0] off_hit;

    always_comb begin
        hit_any  = 1'b0;
        idle_any = 1'b0;
        hit_idx  = '0;
        idle_idx = '0;
        off_hit  = '0;
        // walk downward so the lowest index is the last one written
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (st_arr[i] != V_IDLE && note_arr[i] == cap_note) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (st_arr[i] == V_IDLE) begin
                idle_any = 1'b1;
                idle_idx = IDX_W'(i);
            end
            if (note_arr[i] == cap_note &&
                (st_arr[i] == V_PLUCK || st_arr[i] == V_SUSTAIN ||
                 st_arr[i] == V_REARM)) begin
                off_hit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        old_idx = '0;
        old_age = age_arr[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age_arr[i] > old_age) begin
                old_age = age_arr[i];
                old_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            ctrl       <= C_ACCEPT;
            req_ready  <= 1'b0;
            drop_pulse <= 1'b0;
            cap_on     <= 1'b0;
            cap_note   <= '0;
            note_ok    <= 1'b0;
            tgt        <= '0;
            off_vec    <= '0;
        end else begin
            drop_pulse <= 1'b0;
            unique case (ctrl)
                C_ACCEPT: begin
                    if (req_valid && req_ready) begin
                        cap_on    <= req_on;
                        cap_note  <= req_note;
                        req_ready <= 1'b0;
                        ctrl      <= C_SEARCH;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                C_SEARCH: begin
                    note_ok <= (cap_note >= NOTE_MIN) &&
                               (cap_note <= NOTE_MAX);
                    tgt     <= hit_any  ? hit_idx  :
                               idle_any ? idle_idx : old_idx;
                    off_vec <= off_hit;
                    ctrl    <= C_COMMIT;
                end
                C_COMMIT: begin
                    if (cap_on ? !note_ok : (off_vec == '0)) begin
                        drop_pulse <= 1'b1;
                    end
                    req_ready <= 1'b1;
                    ctrl      <= C_ACCEPT;
                end
                default: begin
                    req_ready <= 1'b0;
                    ctrl      <= C_ACCEPT;
                end
            endcase
        end
    end

    logic [NUM_VOICES-1:0] alloc;
    logic [NUM_VOICES-1:0] rel;

    always_comb begin
        alloc = '0;
        rel   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            alloc[i] = (ctrl == C_COMMIT) && cap_on && note_ok &&
                       (tgt == IDX_W'(i));
            rel[i]   = (ctrl == C_COMMIT) && !cap_on && off_vec[i];
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        vstate_t           st;
        vstate_t           ns;
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  nc;
        logic [7:0]        age;
        logic [7:0]        na;
        logic [NOTE_W-1:0] note;
        logic [NOTE_W-1:0] nn;
        logic [CNT_W-1:0]  pluck_last;
        logic              pluck_r;
        logic [17:0]       gain_r;
        logic              busy_r;

        // pluck lasts note+2 ticks so the string loads note+1 samples
        assign pluck_last = CNT_W'(note) + CNT_W'(1);

        always_comb begin
            ns = st;
            nc = cnt;
            na = age;
            nn = note;
            if (tick && st != V_IDLE && age != 8'hff) begin
                na = age + 8'd1;
            end
            if (tick) begin
                unique case (st)
                    V_REARM: begin
                        if (cnt == REARM_LAST) begin
                            ns = V_PLUCK;
                            nc = '0;
                        end else begin
                            nc = cnt + CNT_W'(1);
                        end
                    end
                    V_PLUCK: begin
                        if (cnt == pluck_last) begin
                            ns = V_SUSTAIN;
                            nc = '0;
                        end else begin
                            nc = cnt + CNT_W'(1);
                        end
                    end
                    V_RELEASE: begin
                        if (cnt == REL_LAST) begin
                            ns = V_IDLE;
                            nc = '0;
                        end else begin
                            nc = cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
            // a commit overrides whatever the tick would have done
            if (alloc[g]) begin
                nn = cap_note;
                na = '0;
                nc = '0;
                ns = (st == V_IDLE || st == V_RELEASE) ? V_PLUCK : V_REARM;
            end else if (rel[g]) begin
                ns = V_RELEASE;
                nc = '0;
            end
        end

        always_ff @(posedge clock50 or posedge reset) begin
            if (reset) begin
                st      <= V_IDLE;
                cnt     <= '0;
                age     <= '0;
                note    <= '0;
                pluck_r <= 1'b0;
                gain_r  <= '0;
                busy_r  <= 1'b0;
            end else begin
                st      <= ns;
                cnt     <= nc;
                age     <= na;
                note    <= nn;
                pluck_r <= (ns == V_PLUCK);
                gain_r  <= (ns == V_IDLE)    ? 18'd0     :
                           (ns == V_RELEASE) ? damp_gain : sustain_gain;
                busy_r  <= (ns != V_IDLE);
            end
        end

        assign st_arr[g]   = st;
        assign age_arr[g]  = age;
        assign note_arr[g] = note;

        assign voice_note[g*NOTE_W +: NOTE_W] = note;
        assign voice_gain[g*18 +: 18]         = gain_r;
        assign voice_pluck[g]                 = pluck_r;
        assign voice_busy[g]                  = busy_r;
    end

endmodule

// File: tb/tb_karplus_voice_alloc.sv
// Directed scoreboard bench for karplus_voice_alloc.
// Tick counts are taken from a local model of the audiolrclk synchronizer.
module tb_karplus_voice_alloc;

    localparam logic [17:0] SG = 18'h2a5c3;
    localparam logic [17:0] DG = 18'h01f0e;

    logic        clock50 = 1'b0;
    logic        reset = 1'b1;
    logic        audiolrclk = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_on = 1'b0;
    logic [8:0]  req_note = '0;
    logic [17:0] sustain_gain = SG;
    logic [17:0] damp_gain = DG;
    logic [35:0] voice_note;
    logic [3:0]  voice_pluck;
    logic [71:0] voice_gain;
    logic [3:0]  voice_busy;
    logic        drop_pulse;

    karplus_voice_alloc dut (
        .clock50      (clock50),
        .reset        (reset),
        .audiolrclk   (audiolrclk),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_on       (req_on),
        .req_note     (req_note),
        .sustain_gain (sustain_gain),
        .damp_gain    (damp_gain),
        .voice_note   (voice_note),
        .voice_pluck  (voice_pluck),
        .voice_gain   (voice_gain),
        .voice_busy   (voice_busy),
        .drop_pulse   (drop_pulse)
    );

    always #5 clock50 = ~clock50;

    initial begin
        #3;
        forever #40 audiolrclk = ~audiolrclk;
    end

    logic [2:0] m;
    logic       mtick;

    always @(posedge clock50 or posedge reset) begin
        if (reset) m <= '0;
        else m <= {m[1:0], audiolrclk};
    end

    assign mtick = m[1] & ~m[2];

    int drop_cnt = 0;

    always @(negedge clock50) begin
        if (drop_pulse === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic fail_timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timeout", tag);
    endtask

    function automatic logic [17:0] gain_of(input int v);
        return 18'(voice_gain >> (18 * v));
    endfunction

    function automatic logic [8:0] note_of(input int v);
        return 9'(voice_note >> (9 * v));
    endfunction

    task automatic send(input logic on, input logic [8:0] note);
        int n = 0;
        @(negedge clock50);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clock50);
            n++;
        end
        if (n >= 100) fail_timeout("send_ready");
        req_valid = 1'b1;
        req_on    = on;
        req_note  = note;
        @(posedge clock50);
        #1 req_valid = 1'b0;
    endtask

    // park at the negedge following the commit edge of the last request
    task automatic post_commit();
        @(posedge clock50);
        @(posedge clock50);
        @(negedge clock50);
    endtask

    // counts ticks processed while the chosen bit holds lvl; kind 0=pluck
    task automatic count_while(input int kind, input logic [1:0] v,
                               input logic lvl, output int n);
        int cyc = 0;
        n = 0;
        while (((kind == 0) ? voice_pluck[v] : voice_busy[v]) === lvl) begin
            if (mtick) n++;
            @(negedge clock50);
            cyc++;
            if (cyc > 60000) begin
                fail_timeout("count_while");
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock50);
        reset = 1'b1;
        @(negedge clock50);
        reset = 1'b0;
        @(posedge clock50);
        #1;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int w;
        #22;
        expect_val("rst_ctrl", 0);
        observe({req_ready, drop_pulse, voice_pluck, voice_busy});
        expect_val("rst_gain", 0);
        observe(voice_gain);
        expect_val("rst_note", 0);
        observe(voice_note);

        @(negedge clock50);
        reset = 1'b0;
        #1;
        expect_val("ready_before_edge", 0);
        observe(req_ready);
        @(posedge clock50);
        #1;
        expect_val("ready_first_edge", 1);
        observe(req_ready);

        send(1'b1, 9'd100);
        post_commit();
        expect_val("n100_pluck", 4'b0001);
        observe(voice_pluck);
        expect_val("n100_note", 100);
        observe(note_of(0));
        expect_val("n100_gain", SG);
        observe(gain_of(0));
        expect_val("n100_busy", 4'b0001);
        observe(voice_busy);
        expect_val("n100_pluck_ticks", 102);
        count_while(0, 2'd0, 1'b1, n);
        observe(n);
        expect_val("n100_sus_gain", SG);
        observe(gain_of(0));
        expect_val("n100_sus_busy", 4'b0001);
        observe(voice_busy);

        do_reset();
        send(1'b1, 9'd50);
        repeat (20) @(negedge clock50);
        send(1'b1, 9'd60);
        repeat (20) @(negedge clock50);
        send(1'b1, 9'd70);
        repeat (20) @(negedge clock50);
        send(1'b1, 9'd80);
        post_commit();
        expect_val("four_busy", 4'hf);
        observe(voice_busy);
        expect_val("four_notes", {9'd80, 9'd70, 9'd60, 9'd50});
        observe(voice_note);

        send(1'b1, 9'd90);
        post_commit();
        expect_val("steal_notes", {9'd80, 9'd70, 9'd60, 9'd90});
        observe(voice_note);
        expect_val("steal_rearm_ticks", 2);
        count_while(0, 2'd0, 1'b0, n);
        observe(n);
        expect_val("steal_pluck_ticks", 92);
        count_while(0, 2'd0, 1'b1, n);
        observe(n);

        expect_val("v1_sustain_pluck", 0);
        observe(voice_pluck[1]);
        send(1'b1, 9'd60);
        post_commit();
        expect_val("retrig_notes", {9'd80, 9'd70, 9'd60, 9'd90});
        observe(voice_note);
        expect_val("retrig_plucks", 0);
        observe(voice_pluck);
        expect_val("retrig_busy", 4'hf);
        observe(voice_busy);
        expect_val("retrig_rearm_ticks", 2);
        count_while(0, 2'd1, 1'b0, n);
        observe(n);
        expect_val("retrig_pluck_ticks", 62);
        count_while(0, 2'd1, 1'b1, n);
        observe(n);

        send(1'b0, 9'd70);
        post_commit();
        expect_val("off_gain", DG);
        observe(gain_of(2));
        expect_val("off_busy", 4'hf);
        observe(voice_busy);
        expect_val("release_ticks", 4800);
        count_while(1, 2'd2, 1'b1, n);
        observe(n);
        expect_val("idle_gain", 0);
        observe(gain_of(2));
        expect_val("idle_busy", 4'b1011);
        observe(voice_busy);
        expect_val("idle_note_kept", 70);
        observe(note_of(2));

        d0 = drop_cnt;
        send(1'b0, 9'd33);
        repeat (5) @(negedge clock50);
        expect_val("drop_off_unmatched", d0 + 1);
        observe(drop_cnt);

        d0 = drop_cnt;
        send(1'b1, 9'd1);
        repeat (5) @(negedge clock50);
        send(1'b1, 9'd510);
        repeat (5) @(negedge clock50);
        expect_val("drop_range", d0 + 2);
        observe(drop_cnt);
        expect_val("drop_notes", {9'd80, 9'd70, 9'd60, 9'd90});
        observe(voice_note);
        expect_val("drop_busy", 4'b1011);
        observe(voice_busy);

        send(1'b1, 9'd2);
        post_commit();
        expect_val("n2_note", 2);
        observe(note_of(2));
        expect_val("n2_pluck", 4'b0100);
        observe(voice_pluck);
        expect_val("n2_pluck_ticks", 4);
        count_while(0, 2'd2, 1'b1, n);
        observe(n);

        w = 0;
        @(negedge clock50);
        while (req_ready !== 1'b1 && w < 100) begin
            @(negedge clock50);
            w++;
        end
        if (w >= 100) fail_timeout("pattern_ready");
        d0 = drop_cnt;
        req_valid = 1'b1;
        req_on    = 1'b0;
        req_note  = 9'd33;
        for (int i = 0; i < 9; i++) begin
            expect_val("ready_pattern", (i % 3) == 0);
            observe(req_ready);
            @(negedge clock50);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clock50);
        expect_val("pattern_drops", d0 + 3);
        observe(drop_cnt);

        send(1'b1, 9'd80);
        post_commit();
        expect_val("r3_rearm_ticks", 2);
        count_while(0, 2'd3, 1'b0, n);
        observe(n);
        repeat (10) @(negedge clock50);
        expect_val("mid_pluck", 1);
        observe(voice_pluck[3]);
        #2 reset = 1'b1;
        #1;
        expect_val("areset_pluck", 0);
        observe(voice_pluck);
        expect_val("areset_gain", 0);
        observe(voice_gain);
        expect_val("areset_ready_busy", 0);
        observe({req_ready, voice_busy});
        @(negedge clock50);
        reset = 1'b0;
        #1;
        expect_val("areset_ready_low", 0);
        observe(req_ready);
        @(posedge clock50);
        #1;
        expect_val("areset_ready_edge", 1);
        observe(req_ready);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
